// File: rtl/quad_pkg.sv
// == quad_pkg: mode encodings, FSM states and default parameters for quad_decoder_gen2 ==
// == rev 1.0 ==
`default_nettype none

package quad_pkg;

  localparam logic [1:0] MODE_X4 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X1 = 2'd2;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CYCLES = 3;

  typedef enum logic [0:0] {
    ST_ARM = 1'b0,
    ST_RUN = 1'b1
  } quad_state_e;

  // Forward order is AB 00->10->11->01: an A move is forward when A!=B afterwards,
  // a B move is forward when A==B afterwards.
  function automatic logic fwd_dir(input logic a_moved, input logic a, input logic b);
    return a_moved ? (a ^ b) : ~(a ^ b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_filter.sv
// == quad_filter: synchroniser chain plus stability filter for one encoder channel ==
// == rev 1.0 ==
`default_nettype none

module quad_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  generate
    if (FILT_CYCLES == 0) begin : g_bypass
      assign dout = w_synced;
    end else begin : g_filter
      localparam int CW = $clog2(FILT_CYCLES + 1);

      logic [CW-1:0] r_cnt;
      logic          r_filt;

      // r_cnt counts consecutive clocks the synced value has differed from the output.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (w_synced == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(FILT_CYCLES - 1)) begin
          r_cnt  <= '0;
          r_filt <= w_synced;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign dout = r_filt;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/quad_decoder_gen2.sv
// == quad_decoder_gen2: filtered x4/x2/x1 quadrature decoder with wrapping position counter ==
// == rev 1.0 -- optional index clear enabled by macro QUAD_INDEX_EN ==
`default_nettype none

module quad_decoder_gen2
  import quad_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             ovf,
  output logic             unf,
  output logic             err
`ifdef QUAD_INDEX_EN
  ,
  input  logic             idx,
  input  logic             idx_clr_en,
  output logic             idx_seen
`endif
);

  localparam int ARM_LEN = SYNC_STAGES + FILT_CYCLES + 1;
  localparam int ARM_W   = $clog2(ARM_LEN + 1);

  logic w_a;
  logic w_b;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_a (
    .clk   (clk),
    .reset (reset),
    .din   (quad_a),
    .dout  (w_a)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_b (
    .clk   (clk),
    .reset (reset),
    .din   (quad_b),
    .dout  (w_b)
  );

  quad_state_e      r_state;
  quad_state_e      w_state_nxt;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [ARM_W-1:0] w_arm_nxt;
  logic             w_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_ARM;
      r_arm_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_arm_cnt <= w_arm_nxt;
    end
  end

  // ARM covers the pipeline fill so stale reset values never look like a transition.
  always_comb begin
    w_state_nxt = r_state;
    w_arm_nxt   = r_arm_cnt;
    case (r_state)
      ST_ARM: begin
        w_arm_nxt = r_arm_cnt + 1'b1;
        if (r_arm_cnt == ARM_W'(ARM_LEN - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  assign w_run = (r_state == ST_RUN);

  logic r_prev_a;
  logic r_prev_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_a <= 1'b0;
      r_prev_b <= 1'b0;
    end else begin
      r_prev_a <= w_a;
      r_prev_b <= w_b;
    end
  end

  logic w_a_chg;
  logic w_b_chg;
  logic w_illegal;
  logic w_req;
  logic w_up;

  assign w_a_chg   = w_a ^ r_prev_a;
  assign w_b_chg   = w_b ^ r_prev_b;
  assign w_illegal = w_run & w_a_chg & w_b_chg;

  always_comb begin
    w_req = 1'b0;
    w_up  = 1'b0;
    if (w_run && !(w_a_chg && w_b_chg)) begin
      case (mode)
        MODE_X2: begin
          if (w_a_chg) begin
            w_req = 1'b1;
            w_up  = fwd_dir(1'b1, w_a, w_b);
          end
        end
        MODE_X1: begin
          if (w_a_chg && w_a) begin
            w_req = 1'b1;
            w_up  = ~w_b;
          end
        end
        default: begin
          if (w_a_chg || w_b_chg) begin
            w_req = 1'b1;
            w_up  = fwd_dir(w_a_chg, w_a, w_b);
          end
        end
      endcase
    end
  end

  logic w_idx_hit;

`ifdef QUAD_INDEX_EN
  logic w_idx;
  logic r_prev_idx;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_filt_idx (
    .clk   (clk),
    .reset (reset),
    .din   (idx),
    .dout  (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_idx <= 1'b0;
      idx_seen   <= 1'b0;
    end else begin
      r_prev_idx <= w_idx;
      if (clear) begin
        idx_seen <= 1'b0;
      end else if (!load && w_idx_hit) begin
        idx_seen <= 1'b1;
      end
    end
  end

  assign w_idx_hit = w_run & idx_clr_en & w_idx & ~r_prev_idx;
`else
  assign w_idx_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      step <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (w_idx_hit) begin
        count <= '0;
      end else if (w_req) begin
        step <= 1'b1;
        dir  <= w_up;
        if (w_up) begin
          count <= count + 1'b1;
          ovf   <= &count;
        end else begin
          count <= count - 1'b1;
          unf   <= ~|count;
        end
      end
    end
  end

  // An illegal transition in the same cycle as err_clr must win.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (w_illegal) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/quad_decoder_gen2.md
Name: quad_decoder_gen2

Overview:
- Parametrised quadrature decoder: synchronises and glitch-filters encoder channels A/B, decodes x4/x2/x1 modes, keeps a wrapping up/down position counter.
- Adds load/clear, overflow/underflow pulses, a sticky illegal-transition error, and an optional index-pulse clear.
- Sits between encoder pins and the register/I2C slave layer, which reads count and drives the control inputs.

Parameters:
- CNT_W, 16, counter width in bits (2..32).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- FILT_CYCLES, 3, consecutive stable clocks needed before a filtered channel changes (0 = filter bypassed).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- quad_a  in  1  encoder channel A, asynchronous.
- quad_b  in  1  encoder channel B, asynchronous.
- mode  in  2  0=x4, 1=x2, 2=x1, 3=reserved (behaves as x4).
- clear  in  1  synchronous count clear.
- load  in  1  synchronous count load.
- load_val  in  CNT_W  value written on load.
- err_clr  in  1  clears sticky error.
- count  out  CNT_W  position counter.
- dir  out  1  direction of last counted step (1=up).
- step  out  1  one-cycle pulse when a step changes count.
- ovf  out  1  one-cycle pulse on wrap from all-ones to 0.
- unf  out  1  one-cycle pulse on wrap from 0 to all-ones.
- err  out  1  sticky illegal-transition flag.
- idx  in  1  index channel (QUAD_INDEX_EN only).
- idx_clr_en  in  1  arm index clear (QUAD_INDEX_EN only).
- idx_seen  out  1  sticky index-clear occurred (QUAD_INDEX_EN only).

Behaviour:
- Reset (while reset=1, on clk): count=0, dir=0, step=0, ovf=0, unf=0, err=0, idx_seen=0; sync/filter flops=0; FSM enters ARM.
- Sync: each input passes through SYNC_STAGES flops. Filter: filtered output takes a new synced value only after it has been held for FILT_CYCLES consecutive clocks.
- Latency: input edge to count update = SYNC_STAGES+FILT_CYCLES+1 clocks.
- FSM ARM -> RUN:
  - ARM lasts SYNC_STAGES+FILT_CYCLES+1 clocks after reset deasserts, with no counting and no err.
  - On its last cycle, the current filtered AB is captured as prev.
  - RUN persists until reset; reset mid-operation returns to ARM.
- Decode: forward sequence AB = 00->10->11->01->00 is up; the reverse is down.
  - x4: every single-channel change counts.
  - x2: only A changes count; direction is up if A!=B after the change.
  - x1: only A rising counts; up if B=0, down if B=1.
- Illegal: A and B change in the same cycle -> no count, err set.
- Priority per cycle: reset > clear (count<=0) > load (count<=load_val) > index clear > step.
  - A step that loses arbitration is dropped: no step/ovf/unf pulse. dir is updated only by counted steps.
- Arithmetic: modulo 2^CNT_W; ovf/unf asserted in the cycle count wraps.
- err_clr clears err; if an illegal transition coincides with err_clr, err stays 1.
- Mode change takes effect next cycle; prev keeps tracking in all modes, so no spurious step.

Optional Feature:
- Macro QUAD_INDEX_EN.
- Defined: idx is synchronised and filtered like A/B. A filtered idx rising edge in RUN with idx_clr_en=1 sets count<=0 (priority above step) and sets idx_seen. idx_seen is cleared by reset or clear.
- Undefined: idx, idx_clr_en and idx_seen ports and all logic are absent.

Decomposition:
- quad_pkg: mode encodings (MODE_X4, MODE_X2, MODE_X1), FSM state enum (ST_ARM, ST_RUN), default parameter constants.
- Sub-module quad_filter: one synchroniser plus stability filter per channel, instantiated 2x (3x with QUAD_INDEX_EN).

Test Plan:
- Reset, defaults, x4: 4 forward quadrature cycles (16 edges, 20 clocks apart) -> count=16, dir=1, 16 step pulses; reverse 3 cycles -> count=4, dir=0.
- x1 then x2, 2 forward cycles each from count=0 -> x1 gives count=2; after clear, x2 gives count=4.
- load_val=16'hFFFF, load, one up step -> count=0 with ovf pulse; one down step -> count=16'hFFFF with unf pulse.
- 2-clock glitch on A (FILT_CYCLES=3) -> count unchanged. AB 00->11 in one clock -> err=1, count unchanged. err_clr with a simultaneous illegal step -> err stays 1.
- clear and an up step in the same cycle -> count=0, no step pulse. Reset asserted mid-sequence with AB=11 -> after ARM, no err and count=0.
- QUAD_INDEX_EN: count=37, idx pulse with idx_clr_en=1 -> count=0, idx_seen=1; same with idx_clr_en=0 -> count unchanged.
